// File: rtl/uart_rx.sv
// 8N1 receiver for the debug UART with in-band ESC/RESUME flow control decoding.
// Optional stop-bit checking is enabled by defining UART_RX_FRAME_ERR_EN.
module uart_rx #(
  parameter int          CLK_RATE  = 100 * 10**6,
  parameter int          BAUD_RATE = 115200,
  parameter logic [7:0]  ESC       = 8'hB1,
  parameter logic [7:0]  RESUME    = 8'h00
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       RX_I,
  input  logic       CHANNEL_I,
  output logic       RX2_O,
  output logic [7:0] DATA_O,
  output logic       RX_DONE_O,
  output logic       PAUSE_O,
  output logic       FRAME_ERR_O,
  output logic [2:0] STATE_O
);

  localparam int BIT_CYC = CLK_RATE / BAUD_RATE;
  localparam int CNT_W   = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYC / 2 - 1);

  typedef enum logic [2:0] {
    st_idle    = 3'd0,
    st_start   = 3'd1,
    st_data    = 3'd2,
    st_stop    = 3'd3,
    st_deliver = 3'd4,
    st_break   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bitnum, bitnum_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             stop_q;
  logic             commit;
  logic             stop_bad;
  logic [7:0]       data_q;
  logic             done_q;
  logic             pause_q;

  assign rx_s = sync[1];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    bitnum_nxt = bitnum;
    shreg_nxt  = shreg;
    commit     = 1'b0;
    case (state)
      st_idle: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = st_start;
      end
      st_start: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt    = '0;
          bitnum_nxt = '0;
          state_nxt  = rx_s ? st_idle : st_data;
        end
      end
      st_data: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt           = '0;
          shreg_nxt[bitnum] = rx_s;
          bitnum_nxt        = bitnum + 3'd1;
          if (bitnum == 3'd7) state_nxt = st_stop;
        end
      end
      st_stop: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          commit    = 1'b1;
          state_nxt = st_deliver;
        end
      end
      st_deliver: begin
        // A low stop bit means the line may be in break; wait for it to go high.
        cnt_nxt   = '0;
        state_nxt = stop_q ? st_idle : st_break;
      end
      st_break: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = st_idle;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = st_idle;
      end
    endcase
    if (CHANNEL_I) begin
      state_nxt  = st_idle;
      cnt_nxt    = '0;
      bitnum_nxt = '0;
      commit     = 1'b0;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  assign stop_bad = ~rx_s;
`else
  assign stop_bad = 1'b0;
`endif

  // Results are registered on the stop-bit sample so they are valid during st_deliver.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state   <= st_idle;
      sync    <= 2'b11;
      cnt     <= '0;
      bitnum  <= '0;
      shreg   <= '0;
      stop_q  <= 1'b1;
      data_q  <= '0;
      done_q  <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sync   <= {sync[0], RX_I};
      cnt    <= cnt_nxt;
      bitnum <= bitnum_nxt;
      shreg  <= shreg_nxt;
      done_q <= 1'b0;
      if (commit) begin
        stop_q <= rx_s;
        if (!stop_bad) begin
          if (shreg == ESC) begin
            pause_q <= 1'b1;
          end else if (shreg == RESUME && pause_q) begin
            pause_q <= 1'b0;
          end else begin
            data_q <= shreg;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  logic ferr_q;
  always_ff @(posedge CLK_I) begin
    if (RST_I) ferr_q <= 1'b0;
    else       ferr_q <= commit & stop_bad;
  end
  assign FRAME_ERR_O = ferr_q & ~CHANNEL_I;
`else
  assign FRAME_ERR_O = 1'b0;
`endif

  assign RX2_O     = CHANNEL_I ? RX_I : 1'b1;
  assign DATA_O    = data_q;
  assign RX_DONE_O = done_q & ~CHANNEL_I;
  assign PAUSE_O   = pause_q;
  assign STATE_O   = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BIT_CYC=10: directed vector table, corner-case sequences and random frames.
module tb_uart_rx;

  localparam int BIT_CYC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       chan;
  logic       rx2;
  logic [7:0] data;
  logic       rx_done;
  logic       pause;
  logic       frame_err;
  logic [2:0] state;

  uart_rx #(
    .CLK_RATE (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .RX_I       (rx),
    .CHANNEL_I  (chan),
    .RX2_O      (rx2),
    .DATA_O     (data),
    .RX_DONE_O  (rx_done),
    .PAUSE_O    (pause),
    .FRAME_ERR_O(frame_err),
    .STATE_O    (state)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         exp_ferr = 0;
  bit         model_paused = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
    bit         exp_done;
    logic [7:0] exp_data;
    bit         exp_pause;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock: monitor outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst == 1'b0) begin
      if (rx_done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got pulse with data %0h, required no pulse", data);
        end else begin
          check("rx_data", data, exp_q.pop_front());
        end
      end
      if (frame_err === 1'b1) ferr_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // Reference decode of one frame from the protocol rules.
  function automatic void model_frame(input logic [7:0] b, input bit stop);
`ifdef UART_RX_FRAME_ERR_EN
    if (!stop) begin
      exp_ferr++;
      return;
    end
`endif
    if (b == 8'hB1) model_paused = 1'b1;
    else if (b == 8'h00 && model_paused) model_paused = 1'b0;
    else exp_q.push_back(b);
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stop, input int chan_bit, input int rst_bit);
    logic bitv;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) bitv = 1'b0;
      else if (i <= 8) bitv = b[i-1];
      else bitv = stop;
      rx = bitv;
      if (i == chan_bit) chan = 1'b1;
      if (i == rst_bit) begin
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_data", data, 8'h00);
        check("rst_done", rx_done, 1'b0);
        check("rst_pause", pause, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_state", state, 3'd0);
        rst = 1'b0;
        rx = 1'b1;
        model_paused = 1'b0;
        return;
      end
      for (int c = 0; c < BIT_CYC; c++) begin
        tick();
        if (chan) check("rx2_follow", rx2, rx);
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    int d0;
    int f0;
    logic [7:0] b;
    bit stop;
    int gap;

    vecs[0]  = '{8'h5A, 1'b1, 2, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[2]  = '{8'h01, 1'b1, 3, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3]  = '{8'hB1, 1'b1, 1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[4]  = '{8'h33, 1'b1, 1, 1'b1, 8'h33, 1'b1, 1'b0};
    vecs[5]  = '{8'h00, 1'b1, 1, 1'b0, 8'h33, 1'b0, 1'b0};
    vecs[6]  = '{8'h00, 1'b1, 1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{8'hB1, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{8'hB1, 1'b1, 2, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 1'b1, 2, 1'b0, 8'h00, 1'b0, 1'b0};
`ifdef UART_RX_FRAME_ERR_EN
    vecs[10] = '{8'h81, 1'b0, 4, 1'b0, 8'h00, 1'b0, 1'b1};
`else
    vecs[10] = '{8'h81, 1'b0, 4, 1'b1, 8'h81, 1'b0, 1'b0};
`endif
    vecs[11] = '{8'h7E, 1'b1, 2, 1'b1, 8'h7E, 1'b0, 1'b0};

    // Clock/reset
    rst  = 1'b1;
    rx   = 1'b1;
    chan = 1'b0;
    repeat (3) tick();
    check("reset_data", data, 8'h00);
    check("reset_done", rx_done, 1'b0);
    check("reset_pause", pause, 1'b0);
    check("reset_ferr", frame_err, 1'b0);
    check("reset_state", state, 3'd0);
    check("reset_rx2", rx2, 1'b1);
    rst = 1'b0;
    idle(5);

    // Directed vector table
    foreach (vecs[i]) begin
      d0 = done_cnt;
      f0 = ferr_cnt;
      if (vecs[i].exp_done) exp_q.push_back(vecs[i].exp_data);
      send_frame(vecs[i].data, vecs[i].stop, -1, -1);
      check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_pause", i), pause, vecs[i].exp_pause);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      exp_ferr += vecs[i].exp_ferr;
      model_paused = vecs[i].exp_pause;
      if (vecs[i].gap > 0) idle(vecs[i].gap);
    end

    // Short low glitch is rejected by the start-bit mid-sample
    d0 = done_cnt;
    rx = 1'b0;
    repeat (4) tick();
    idle(20);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_state", state, 3'd0);

    // CHANNEL_I asserted during data bit 3 discards the frame
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, 4, -1);
    chan = 1'b0;
    idle(3);
    check("chan_done", done_cnt - d0, 0);
    check("chan_state", state, 3'd0);
    check("chan_rx2_idle", rx2, 1'b1);
    check("chan_pause", pause, model_paused);
    model_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1, -1, -1);
    check("after_chan_data", data, 8'h3C);
    idle(2);

    // Reset mid-frame while paused
    model_frame(8'hB1, 1'b1);
    send_frame(8'hB1, 1'b1, -1, -1);
    check("pre_rst_pause", pause, 1'b1);
    idle(2);
    send_frame(8'h6C, 1'b1, -1, 5);
    idle(30);
    check("post_rst_pause", pause, 1'b0);
    check("post_rst_state", state, 3'd0);

    // Random frames against the reference model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hB1;
        1: b = 8'h00;
        default: b = 8'($urandom_range(0, 255));
      endcase
      stop = ($urandom_range(0, 7) != 0);
      gap  = stop ? $urandom_range(0, 3) : $urandom_range(4, 6);
      model_frame(b, stop);
      send_frame(b, stop, -1, -1);
      check($sformatf("rnd%0d_pause", n), pause, model_paused);
      if (gap > 0) idle(gap);
    end

    idle(10);
    check("exp_q_drained", exp_q.size(), 0);
    check("ferr_total", ferr_cnt, exp_ferr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
